seven_seg_capture: RTL and testbench
====================================

SEVEN_SEG_CAPTURE -- requirements
Module: seven_seg_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, range 1..255: consecutive unchanged cycles required before a digit is accepted.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 an0, an1, an2, an3  input  1 each  digit anodes, active-low, an0 = rightmost digit.
REQ-005 a, b, c, d, e, f, g  input  1 each  segments, active-low; pattern seg[6:0] = {a,b,c,d,e,f,g}.
REQ-006 dp  input  1  decimal point, active-low.
REQ-007 char0, char1, char2, char3  output  4 each  last decoded hex value per digit.
REQ-008 digit_err  output  4  bit n set = last pattern on digit n was not a hex glyph.
REQ-009 frame_word  output  16  {char3,char2,char1,char0} snapshot of the last complete frame.
REQ-010 frame_done  output  1  one-cycle pulse when frame_word updates.
REQ-011 bus_err  output  1  one-cycle pulse on illegal anode state.
REQ-012 dp_out  output  4  captured decimal point per digit, 1 = lit.

Function
REQ-013 Inputs {an3..an0, seg, dp} SHALL be registered once per clk; all logic below uses the registered copy.
REQ-014 stab_cnt (8 bit) SHALL increment, saturating at STABLE_CYCLES, when the registered word equals its previous-cycle value and exactly one anode is low; otherwise it SHALL clear to 0.
REQ-015 Capture SHALL occur on the edge where stab_cnt goes from STABLE_CYCLES-1 to STABLE_CYCLES; at most one capture per dwell.
REQ-016 Stable input present before edge E SHALL appear on charN by edge E+STABLE_CYCLES.
REQ-017 Decode table (seg -> char): 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 0001000->A, 1100000->b, 0110001->C, 1000010->d, 0110000->E, 0111000->F.
REQ-018 Valid glyph: charN updated, digit_err[N] cleared; other pattern: charN held, digit_err[N] set.
REQ-019 seen_mask[3:0] SHALL set bit N on each capture of digit N (valid or not).
REQ-020 When seen_mask would become 4'b1111, the same edge SHALL load frame_word with the updated chars, pulse frame_done, and clear seen_mask.
REQ-021 All anodes high (blanking) SHALL clear stab_cnt only; no error.
REQ-022 Two or more anodes low SHALL pulse bus_err, clear stab_cnt and seen_mask.
REQ-023 Repeated capture of same digit before frame completion SHALL overwrite charN and leave seen_mask bit set.
REQ-024 Simultaneous bus_err and capture cannot occur (capture requires one-hot anodes).

Reset
REQ-025 rst low SHALL immediately force: char0..3 = 0, digit_err = 0, frame_word = 0, frame_done = 0, bus_err = 0, dp_out = 0, seen_mask = 0, stab_cnt = 0, input register = all ones.
REQ-026 Reset asserted mid-dwell or mid-frame SHALL discard partial progress; first capture after release needs full STABLE_CYCLES dwell.

Configuration
REQ-027 Macro SEG_CAPTURE_DP_EN defined: dp_out[N] SHALL load ~dp on each capture of digit N.
REQ-028 Macro undefined: dp input ignored, excluded from stability compare, dp_out tied to 4'b0000.

Verification
REQ-029 Reset release, scan an0..an3 low in turn, 8 cycles each, seg for 1,2,3,4 -> char0..3 = 1,2,3,4, frame_word = 16'h4321, one frame_done pulse.
REQ-030 STABLE_CYCLES=4, an1 low with seg 0001000 held exactly 3 cycles then changed -> char1 unchanged; held 5 cycles -> char1 = A at edge E+4.
REQ-031 an2 low, seg 1111111 stable -> digit_err = 4'b0100, char2 holds prior value.
REQ-032 an0 and an3 low together -> bus_err one-cycle pulse, seen_mask cleared, next frame needs all four digits.
REQ-033 rst low after two digits captured -> all outputs 0 asynchronously; subsequent full scan produces frame_done only after four new captures.
REQ-034 With SEG_CAPTURE_DP_EN, dp low on digit 1 only -> dp_out = 4'b0010; without macro -> dp_out = 4'b0000.

Source files
------------

// File: rtl/seven_seg_capture.sv
// Samples a multiplexed active-low 7-segment bus, decodes stable glyphs per digit and snapshots complete 4-digit frames.
// Define SEG_CAPTURE_DP_EN to also capture each digit's decimal point onto dp_out.
module seven_seg_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        an0,
  input  logic        an1,
  input  logic        an2,
  input  logic        an3,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  input  logic        e,
  input  logic        f,
  input  logic        g,
  input  logic        dp,
  output logic [3:0]  char0,
  output logic [3:0]  char1,
  output logic [3:0]  char2,
  output logic [3:0]  char3,
  output logic [3:0]  digit_err,
  output logic [15:0] frame_word,
  output logic        frame_done,
  output logic        bus_err,
  output logic [3:0]  dp_out
);

  localparam logic [7:0] L_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] L_PRE = 8'(STABLE_CYCLES - 1);

  logic [10:0]     r_in;
  logic [7:0]      r_stab_cnt;
  logic [3:0]      r_seen;
  logic [3:0][3:0] r_chars;
  logic [3:0]      r_err;
  logic [15:0]     r_frame_word;
  logic            r_frame_done;
  logic            r_bus_err;
  logic            r_multi_prev;

  logic [10:0]     w_raw;
  logic [3:0]      w_an;
  logic [6:0]      w_seg;
  logic [3:0]      w_dig;
  logic            w_onehot;
  logic            w_multi;
  logic            w_same;
  logic            w_cap;
  logic [1:0]      w_idx;
  logic [4:0]      w_dec;
  logic [3:0][3:0] w_chars_nxt;

  assign w_raw = {an3, an2, an1, an0, a, b, c, d, e, f, g};
  assign w_an  = r_in[10:7];
  assign w_seg = r_in[6:0];
  assign w_dig = ~w_an;

  // Comparing the incoming word against the registered one lets a dwell
  // starting at edge E reach the capture threshold exactly at E+STABLE_CYCLES.
`ifdef SEG_CAPTURE_DP_EN
  logic       r_dp;
  logic [3:0] r_dp_out;
  assign w_same = (w_raw == r_in) && (dp == r_dp);
`else
  assign w_same = (w_raw == r_in);
`endif

  always_comb begin
    w_onehot = 1'b1;
    w_idx    = 2'd0;
    case (w_an)
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_onehot = 1'b0;
    endcase
  end

  assign w_multi = !w_onehot && (w_an != 4'b1111);
  assign w_cap   = w_same && w_onehot && (r_stab_cnt == L_PRE);

  // Result is {valid, hex value}; invalid patterns return 0 with valid low.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    logic [4:0] v;
    case (s)
      7'b0000001: v = {1'b1, 4'h0};
      7'b1001111: v = {1'b1, 4'h1};
      7'b0010010: v = {1'b1, 4'h2};
      7'b0000110: v = {1'b1, 4'h3};
      7'b1001100: v = {1'b1, 4'h4};
      7'b0100100: v = {1'b1, 4'h5};
      7'b0100000: v = {1'b1, 4'h6};
      7'b0001111: v = {1'b1, 4'h7};
      7'b0000000: v = {1'b1, 4'h8};
      7'b0000100: v = {1'b1, 4'h9};
      7'b0001000: v = {1'b1, 4'hA};
      7'b1100000: v = {1'b1, 4'hB};
      7'b0110001: v = {1'b1, 4'hC};
      7'b1000010: v = {1'b1, 4'hD};
      7'b0110000: v = {1'b1, 4'hE};
      7'b0111000: v = {1'b1, 4'hF};
      default:    v = 5'b0_0000;
    endcase
    return v;
  endfunction

  assign w_dec = seg_decode(w_seg);

  always_comb begin
    w_chars_nxt = r_chars;
    if (w_cap && w_dec[4]) begin
      w_chars_nxt[w_idx] = w_dec[3:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in         <= '1;
      r_stab_cnt   <= 8'd0;
      r_seen       <= 4'b0000;
      r_chars      <= '0;
      r_err        <= 4'b0000;
      r_frame_word <= 16'h0000;
      r_frame_done <= 1'b0;
      r_bus_err    <= 1'b0;
      r_multi_prev <= 1'b0;
    end else begin
      r_in         <= w_raw;
      r_multi_prev <= w_multi;
      r_bus_err    <= w_multi && !r_multi_prev;
      r_frame_done <= 1'b0;

      if (w_same && w_onehot) begin
        r_stab_cnt <= (r_stab_cnt == L_MAX) ? L_MAX : 8'(r_stab_cnt + 8'd1);
      end else begin
        r_stab_cnt <= 8'd0;
      end

      if (w_multi) begin
        r_seen <= 4'b0000;
      end else if (w_cap) begin
        r_chars      <= w_chars_nxt;
        r_err[w_idx] <= !w_dec[4];
        if ((r_seen | w_dig) == 4'b1111) begin
          r_frame_word <= w_chars_nxt;
          r_frame_done <= 1'b1;
          r_seen       <= 4'b0000;
        end else begin
          r_seen <= r_seen | w_dig;
        end
      end
    end
  end

`ifdef SEG_CAPTURE_DP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dp     <= 1'b1;
      r_dp_out <= 4'b0000;
    end else begin
      r_dp <= dp;
      if (w_cap) begin
        r_dp_out[w_idx] <= !r_dp;
      end
    end
  end
  assign dp_out = r_dp_out;
`else
  // dp is ignored in this build; the mask keeps the port referenced.
  assign dp_out = 4'b0000 & {4{dp}};
`endif

  assign char0      = r_chars[0];
  assign char1      = r_chars[1];
  assign char2      = r_chars[2];
  assign char3      = r_chars[3];
  assign digit_err  = r_err;
  assign frame_word = r_frame_word;
  assign frame_done = r_frame_done;
  assign bus_err    = r_bus_err;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed scoreboard bench for seven_seg_capture with STABLE_CYCLES = 4.
module tb_seven_seg_capture;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  an    = 4'b1111;
  logic [6:0]  seg   = 7'h7F;
  logic        dp    = 1'b1;

  logic [3:0]  char0, char1, char2, char3, digit_err, dp_out;
  logic [15:0] frame_word;
  logic        frame_done, bus_err;

  int          tests = 0;
  int          fails = 0;
  int          frames = 0;
  int          bus_pulses = 0;
  logic [15:0] exp_q[$];

  seven_seg_capture #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst_n),
    .an0(an[0]), .an1(an[1]), .an2(an[2]), .an3(an[3]),
    .a(seg[6]), .b(seg[5]), .c(seg[4]), .d(seg[3]), .e(seg[2]), .f(seg[1]), .g(seg[0]),
    .dp(dp),
    .char0(char0), .char1(char1), .char2(char2), .char3(char3),
    .digit_err(digit_err), .frame_word(frame_word), .frame_done(frame_done),
    .bus_err(bus_err), .dp_out(dp_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Hold one bus state for n clock edges; called from a falling edge.
  task automatic show(input logic [3:0] a_n, input logic [6:0] s, input logic d, input int n);
    an  = a_n;
    seg = s;
    dp  = d;
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor: every frame_done pops one expected frame word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done) begin
        frames++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL frame_unexpected: got %h expected no frame", frame_word);
        end else begin
          logic [15:0] exp_w;
          exp_w = exp_q.pop_front();
          if (frame_word !== exp_w) begin
            fails++;
            $display("FAIL frame_word: got %h expected %h", frame_word, exp_w);
          end
        end
      end
      if (bus_err) bus_pulses++;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int f0;
    int b0;
    logic [3:0] exp_dp;
`ifdef SEG_CAPTURE_DP_EN
    exp_dp = 4'b0010;
`else
    exp_dp = 4'b0000;
`endif

    repeat (3) @(negedge clk);
    check("rst_char0", char0, 0);
    check("rst_char3", char3, 0);
    check("rst_digit_err", digit_err, 0);
    check("rst_frame_word", frame_word, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_dp_out", dp_out, 0);
    rst_n = 1'b1;

    // Basic scan 1,2,3,4
    exp_q.push_back(16'h4321);
    show(4'b1110, 7'h4F, 1'b1, 8);
    show(4'b1101, 7'h12, 1'b1, 8);
    show(4'b1011, 7'h06, 1'b1, 8);
    show(4'b0111, 7'h4C, 1'b1, 8);
    check("scan_char0", char0, 4'h1);
    check("scan_char1", char1, 4'h2);
    check("scan_char2", char2, 4'h3);
    check("scan_char3", char3, 4'h4);
    check("scan_frames", frames, 1);

    // Dwell threshold on digit 1
    show(4'b1111, 7'h7F, 1'b1, 3);
    show(4'b1101, 7'h08, 1'b1, 3);
    show(4'b1111, 7'h7F, 1'b1, 2);
    check("short_dwell_char1", char1, 4'h2);
    show(4'b1101, 7'h08, 1'b1, 4);
    check("dwell_edge3_char1", char1, 4'h2);
    show(4'b1101, 7'h08, 1'b1, 1);
    check("dwell_edge4_char1", char1, 4'hA);

    // Non-glyph on digit 2
    show(4'b1011, 7'h7F, 1'b1, 6);
    check("bad_digit_err", digit_err, 4'b0100);
    check("bad_char2_hold", char2, 4'h3);

    // Two anodes low: one bus_err pulse and seen mask cleared
    b0 = bus_pulses;
    show(4'b0110, 7'h7F, 1'b1, 3);
    show(4'b1111, 7'h7F, 1'b1, 2);
    check("bus_err_pulses", bus_pulses - b0, 1);
    exp_q.push_back(16'h8EB5);
    show(4'b1110, 7'h24, 1'b1, 8);
    show(4'b0111, 7'h00, 1'b1, 8);
    f0 = frames;
    show(4'b1101, 7'h60, 1'b0, 8);
    show(4'b1011, 7'h30, 1'b1, 8);
    check("bus_frame_after_four", frames - f0, 1);
    check("bus_digit_err", digit_err, 0);
    check("dp_out", dp_out, exp_dp);

    // Reset after two digits captured
    show(4'b1111, 7'h7F, 1'b1, 2);
    show(4'b1110, 7'h4F, 1'b1, 8);
    show(4'b1101, 7'h12, 1'b1, 8);
    #2 rst_n = 1'b0;
    #1;
    check("async_char0", char0, 0);
    check("async_char1", char1, 0);
    check("async_frame_word", frame_word, 0);
    check("async_dp_out", dp_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    f0 = frames;
    exp_q.push_back(16'h43C9);
    show(4'b1011, 7'h06, 1'b1, 8);
    show(4'b0111, 7'h4C, 1'b1, 8);
    check("post_rst_no_frame", frames - f0, 0);
    show(4'b1110, 7'h04, 1'b1, 8);
    show(4'b1101, 7'h31, 1'b1, 8);
    check("post_rst_frame", frames - f0, 1);
    check("post_rst_char1", char1, 4'hC);
    check("pending_frames", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
